// File: rtl/skew_feeder.sv
// Column sequencer for the 4x4 byte column memory: reads N columns and re-times
// them into a diagonal wavefront where lane k lags lane 0 by k cycles.
module skew_feeder #(
  parameter int DATA_W = 8,
  parameter int N      = 4,
  parameter int SEL_W  = $clog2(N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                en,
  output logic [SEL_W-1:0]    col_sel,
  input  logic [N*DATA_W-1:0] col_in,
  output logic [N*DATA_W-1:0] row_out,
  output logic [N-1:0]        valid_out,
  output logic                busy,
  output logic                done,
  output logic [1:0]          dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [SEL_W-1:0] COL_LAST = SEL_W'(N - 1);
  localparam logic [SEL_W-1:0] DRN_LAST = SEL_W'(N - 2);

  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] drn_q, drn_d;
  logic             feeding;

  // cnt_q doubles as col_sel: it parks at N-1 through DRAIN/DONE and is zero in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FEED;
          cnt_d   = '0;
        end
      end
      S_FEED: begin
        if (cnt_q == COL_LAST) begin
          state_d = S_DRAIN;
          drn_d   = '0;
        end else begin
          cnt_d = cnt_q + SEL_W'(1);
        end
      end
      S_DRAIN: begin
        if (drn_q == DRN_LAST) begin
          state_d = S_DONE;
        end else begin
          drn_d = drn_q + SEL_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      drn_q   <= '0;
    end else if (en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
    end
  end

  assign feeding   = (state_q == S_FEED);
  assign col_sel   = cnt_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE) && en;
  assign dbg_state = state_q;

  // Lane k is a (k+1)-deep shift register; its oldest stage drives the output.
  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [(k+1)*DATA_W-1:0] dq_q;
    logic [k:0]              vq_q;
    logic [DATA_W-1:0]       lane_in;

    assign lane_in = feeding ? col_in[k*DATA_W +: DATA_W] : '0;

    if (k == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (reset) begin
          dq_q <= '0;
          vq_q <= '0;
        end else if (en) begin
          dq_q <= lane_in;
          vq_q <= feeding;
        end
      end
    end else begin : g_rest
      always_ff @(posedge clk) begin
        if (reset) begin
          dq_q <= '0;
          vq_q <= '0;
        end else if (en) begin
          dq_q <= {dq_q[k*DATA_W-1:0], lane_in};
          vq_q <= {vq_q[k-1:0], feeding};
        end
      end
    end

    assign row_out[k*DATA_W +: DATA_W] = dq_q[k*DATA_W +: DATA_W];
    assign valid_out[k]                = vq_q[k];
  end

endmodule

// File: tb/tb_skew_feeder.sv
// Vector-table bench for skew_feeder, with a behavioural column memory holding
// byte r*4+c at row r, column c.
module tb_skew_feeder;

  localparam int DATA_W = 8;
  localparam int N      = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic          en;
  logic [1:0]    col_sel;
  logic [31:0]   col_in;
  logic [31:0]   row_out;
  logic [3:0]    valid_out;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  int n_checks;
  int n_fail;

  skew_feeder #(.DATA_W(DATA_W), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .en        (en),
    .col_sel   (col_sel),
    .col_in    (col_in),
    .row_out   (row_out),
    .valid_out (valid_out),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // combinational column memory
  assign col_in = {8'(12 + col_sel), 8'(8 + col_sel), 8'(4 + col_sel), 8'(col_sel)};

  typedef struct {
    string       name;
    logic        rst;
    logic        st;
    logic        en;
    logic [1:0]  sel;
    logic [31:0] row;
    logic [3:0]  vld;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vecs[$];

  // t is the advancing-cycle index from F0 (-1 = idle). Lane k shows column t-k-1.
  function automatic vec_t mk(string name, logic rst, logic st, logic en_v, int t);
    vec_t v;
    int c;
    v.name = name;
    v.rst  = rst;
    v.st   = st;
    v.en   = en_v;
    v.sel  = 2'd0;
    v.row  = '0;
    v.vld  = '0;
    v.busy = (t >= 0) && (t <= 7);
    v.done = (t == 7) && en_v;
    if (t >= 0 && t <= 3) v.sel = 2'(t);
    else if (t >= 4 && t <= 7) v.sel = 2'd3;
    for (int k = 0; k < 4; k++) begin
      c = t - k - 1;
      if (t >= 0 && c >= 0 && c <= 3) begin
        v.vld[k]        = 1'b1;
        v.row[k*8 +: 8] = 8'(4 * k + c);
      end
    end
    return v;
  endfunction

  task automatic check(string name, string what, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h at %0t", name, what, act, exp, $time);
    end
  endtask

  task automatic apply(vec_t v);
    @(negedge clk);
    reset = v.rst;
    start = v.st;
    en    = v.en;
    #1;
    check(v.name, "col_sel", 32'(col_sel), 32'(v.sel));
    check(v.name, "row_out", row_out, v.row);
    check(v.name, "valid_out", 32'(valid_out), 32'(v.vld));
    check(v.name, "busy", 32'(busy), 32'(v.busy));
    check(v.name, "done", 32'(done), 32'(v.done));
  endtask

  int first_done;
  int second_done;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    en       = 1'b1;
    repeat (2) @(posedge clk);

    vecs.push_back(mk("reset", 1, 1, 0, -1));
    vecs.push_back(mk("idle", 0, 0, 1, -1));

    vecs.push_back(mk("basic", 0, 1, 1, -1));
    for (int t = 0; t < 8; t++) vecs.push_back(mk("basic", 0, 0, 1, t));
    vecs.push_back(mk("basic", 0, 0, 1, -1));

    vecs.push_back(mk("stall", 0, 1, 1, -1));
    vecs.push_back(mk("stall", 0, 0, 1, 0));
    vecs.push_back(mk("stall", 0, 0, 1, 1));
    vecs.push_back(mk("stall", 0, 0, 0, 2));
    vecs.push_back(mk("stall", 0, 0, 0, 2));
    for (int t = 2; t < 8; t++) vecs.push_back(mk("stall", 0, 0, 1, t));
    vecs.push_back(mk("stall", 0, 0, 1, -1));

    vecs.push_back(mk("done_stall", 0, 1, 1, -1));
    for (int t = 0; t < 7; t++) vecs.push_back(mk("done_stall", 0, 0, 1, t));
    vecs.push_back(mk("done_stall", 0, 0, 0, 7));
    vecs.push_back(mk("done_stall", 0, 0, 1, 7));
    vecs.push_back(mk("done_stall", 0, 0, 1, -1));

    vecs.push_back(mk("start_busy", 0, 1, 1, -1));
    vecs.push_back(mk("start_busy", 0, 0, 1, 0));
    vecs.push_back(mk("start_busy", 0, 1, 1, 1));
    for (int t = 2; t < 7; t++) vecs.push_back(mk("start_busy", 0, 0, 1, t));
    vecs.push_back(mk("start_busy", 0, 1, 1, 7));
    vecs.push_back(mk("start_busy", 0, 0, 1, -1));
    vecs.push_back(mk("start_busy", 0, 0, 1, -1));

    vecs.push_back(mk("b2b", 0, 1, 1, -1));
    for (int t = 0; t < 8; t++) vecs.push_back(mk("b2b", 0, 1, 1, t));
    vecs.push_back(mk("b2b", 0, 1, 1, -1));
    for (int t = 0; t < 8; t++) vecs.push_back(mk("b2b", 0, 1, 1, t));
    vecs.push_back(mk("b2b", 0, 0, 1, -1));

    vecs.push_back(mk("rst_mid", 0, 1, 1, -1));
    for (int t = 0; t < 5; t++) vecs.push_back(mk("rst_mid", 0, 0, 1, t));
    vecs.push_back(mk("rst_mid", 1, 0, 1, 5));
    vecs.push_back(mk("rst_mid", 0, 0, 1, -1));
    vecs.push_back(mk("rst_mid", 0, 0, 1, -1));

    vecs.push_back(mk("rst_start", 1, 1, 1, -1));
    vecs.push_back(mk("rst_start", 0, 0, 1, -1));

    foreach (vecs[i]) apply(vecs[i]);

    // Hand sequence: start held high, measure the spacing between done pulses.
    @(negedge clk);
    reset       = 1'b0;
    en          = 1'b1;
    start       = 1'b1;
    first_done  = -1;
    second_done = -1;
    for (int i = 0; i < 40 && second_done < 0; i++) begin
      #1;
      if (done) begin
        if (first_done < 0) first_done = i;
        else second_done = i;
      end
      @(negedge clk);
    end
    check("b2b_hand", "seen_two_dones", 32'(second_done >= 0), 32'd1);
    check("b2b_hand", "done_spacing", 32'(second_done - first_done), 32'd9);
    start = 1'b0;

    // Hand sequence: start pulsed while en=0 in IDLE must not be taken.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b0;
    start = 1'b1;
    @(negedge clk);
    en    = 1'b1;
    start = 1'b0;
    #1;
    check("start_no_en", "busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/skew_feeder.md
Name: skew_feeder

Overview:
- Downstream consumer of the 4x4 byte column memory.
- Sequences column reads (column 0..N-1) from the memory's combinational column output.
- Re-times each column into a diagonally skewed wavefront: lane k is delayed k extra cycles, so the systolic array's row k receives its operand k cycles after row 0.
- Emits per-lane valid bits, plus busy and a one-cycle done pulse, to the array controller.

Parameters:
- DATA_W, 8, width of one matrix element (one lane).
- N, 4, matrix dimension (lanes and columns). Must be a power of two, >= 2.
- SEL_W, $clog2(N), width of col_sel.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, request one full N-column feed; sampled only in IDLE with en=1.
- en, input, 1, global advance. When 0, all state, counters and lane registers hold.
- col_sel, output, SEL_W, column index to memory (drives memory addr[1:0]).
- col_in, input, N*DATA_W, column data from memory. Byte k = row k of the selected column; valid in the same cycle as col_sel (combinational read).
- row_out, output, N*DATA_W, skewed lane data. Lane k is bits [k*DATA_W +: DATA_W].
- valid_out, output, N, per-lane valid qualifying row_out.
- busy, output, 1, high whenever state != IDLE.
- done, output, 1, one-cycle pulse when the final lane output is presented.

Behaviour:
- Reset (synchronous, has priority over everything, including en=0 and start): state=IDLE, column counter=0, all lane shift registers (data and valid) cleared. Outputs: col_sel=0, row_out=0, valid_out=0, busy=0, done=0.
- FSM states are IDLE, FEED, DRAIN and DONE. All transitions occur only on cycles with en=1. With en=0 every register holds and outputs are unchanged.
- IDLE:
  - col_sel=0; lanes shift in zeros.
  - start=1 and en=1 -> FEED with counter=0. The first FEED cycle is the next cycle and is called cycle F0.
- FEED: lasts N advancing cycles, Ff for f=0..N-1.
  - col_sel=f.
  - col_in byte k is loaded into lane k's delay line together with valid=1.
  - After FEED cycle F(N-1) -> DRAIN.
- DRAIN: lasts N-1 advancing cycles.
  - col_sel holds N-1.
  - Lanes shift in data=0, valid=0.
  - Then -> DONE.
- DONE: lasts 1 advancing cycle.
  - done=1; then -> IDLE.
  - done must not assert if en=0 in that cycle; the pulse is emitted on the cycle DONE advances.
- Lane k delay line is k+1 registers deep, so the byte captured in FEED cycle f appears on lane k in cycle f+k+1, counted in advancing cycles from F0.
  - valid_out[k]=1 exactly in cycles k+1..k+N.
  - Outside that window, row_out lane k = 0.
- Timing for N=4:
  - lane 0 is valid in cycles 1-4; lane 3 is valid in cycles 4-7.
  - DONE is cycle 7, coinciding with lane 3's last valid byte (column 3, row 3).
  - IDLE resumes at cycle 8.
  - Latency is 2N cycles from start acceptance to done.
- start while busy (FEED/DRAIN/DONE) is ignored, not queued. The earliest accepted restart is the first IDLE cycle after DONE.
- Reset mid-operation aborts immediately: lanes are zeroed and no done pulse is issued.
- No arithmetic. The counter wraps only via state exit; col_sel never exceeds N-1.

Test Plan:
- Basic: memory rows r hold bytes {r*4+c} (i.e., col_in for column c = {12+c, 8+c, 4+c, c}); pulse start -> lane 0 shows 0,1,2,3 in cycles 1-4; lane 3 shows 12,13,14,15 in cycles 4-7; valid_out matches the windows; done=1 only in cycle 7; busy high cycles 0-7 after acceptance.
- Stall: as Basic, but en=0 for 2 cycles at FEED cycle 2 -> col_sel holds 2, row_out/valid_out frozen during the stall, sequence resumes unchanged and done is delayed by exactly 2 cycles.
- Start while busy: re-pulse start in FEED cycle 1 and again in DONE -> ignored; exactly one done pulse; IDLE reached at cycle 8.
- Back-to-back: start held high continuously -> second FEED begins the cycle after the first return to IDLE (cycle 9); done pulses 9 cycles apart.
- Reset mid-operation: assert reset in DRAIN cycle 5 -> the next cycle shows row_out=0, valid_out=0, busy=0, col_sel=0; done never asserts.
- Reset/start collision: reset=1 and start=1 in the same cycle -> stays IDLE, busy=0 the next cycle.
